uart_cmd_rx: RTL

- UART receive-side companion to the debug printer.
- Deserialises host bytes from the board's RX pin at the printer's baud rate.
- Decodes single-character debug commands into one-cycle control pulses: start print round, single-step, CPU reset.
- Parses "b<hex>" lines into a breakpoint address register that the CPU top compares against pc.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx.sv | 155 +++++++++++++++
 rtl/uart_cmd_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants, state encodings and helpers used by the UART receiver
// (uart_rx) and by the debug-command parser (uart_cmd_rx).
package uart_pkg;

    localparam logic [7:0] CMD_PRINT = 8'h70;  // 'p'
    localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_RST   = 8'h72;  // 'r'
    localparam logic [7:0] CMD_BP    = 8'h62;  // 'b'
    localparam logic [7:0] CMD_CLR   = 8'h63;  // 'c'
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;
    localparam logic [7:0] SP        = 8'h20;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
    typedef enum logic {CMD, HEX} parse_state_t;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int sys_clk_freq, input int baud_rate,
                                    input int oversample);
        return sys_clk_freq / (baud_rate * oversample);
    endfunction

    // {is_hex, value}; accepts 0-9, a-f, A-F.
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
            r = {1'b1, c[3:0] + 4'd9};  // low nibble of 'a'/'A' is 1
        return r;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchroniser and oversampled
// baud tick. Reusable by any byte consumer.
//   clk, rst      clock, synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   rx_byte       last correctly framed byte (valid while rx_valid is high)
//   rx_valid      one-cycle pulse when rx_byte updates
//   frame_err     one-cycle pulse when the stop bit is sampled low
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | confirming start bit at its midpoint
// DATA  | sampling 8 data bits, LSB first, one per bit-time
// STOP  | sampling stop bit
// BREAK | stop bit was low, waiting for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int baud_rate    = 9600,
    parameter int sys_clk_freq = 100_000_000,
    parameter int oversample   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int DIV  = calc_div(sys_clk_freq, baud_rate, oversample);
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW   = (oversample > 1) ? $clog2(oversample) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(oversample / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(oversample - 1);

    logic          rx_meta, rxs;
    logic [CW-1:0] baud_cnt;
    logic          tick, clr_baud;

    rx_state_t     state, state_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [2:0]    bitn, bitn_nx;
    logic [7:0]    shift, shift_nx, byte_nx;
    logic          valid_nx, ferr_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Re-phased on the start edge so the midpoint samples land mid-bit.
    assign tick = (baud_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr_baud || tick)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            bitn      <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            tcnt      <= tcnt_nx;
            bitn      <= bitn_nx;
            shift     <= shift_nx;
            rx_byte   <= byte_nx;
            rx_valid  <= valid_nx;
            frame_err <= ferr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        bitn_nx  = bitn;
        shift_nx = shift;
        byte_nx  = rx_byte;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
        clr_baud = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nx = START;
                    tcnt_nx  = '0;
                    clr_baud = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (tcnt == T_HALF) begin
                        if (!rxs) begin
                            state_nx = DATA;
                            tcnt_nx  = '0;
                            bitn_nx  = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt == T_FULL) begin
                        tcnt_nx  = '0;
                        shift_nx = {rxs, shift[7:1]};
                        bitn_nx  = bitn + 1'b1;
                        if (bitn == 3'd7)
                            state_nx = STOP;
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tcnt == T_FULL) begin
                        if (rxs) begin
                            byte_nx  = shift;
                            valid_nx = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            ferr_nx  = 1'b1;
                            state_nx = BREAK;
                        end
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rxs)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: debug command receiver. Turns single-character host commands
// into one-cycle pulses and parses "b<hex>" lines into a breakpoint address.
//   clk, rst                  clock, synchronous active-high reset
//   rx                        serial input, idle high
//   rx_byte/rx_valid          received byte and its one-cycle strobe
//   frame_err                 one-cycle pulse on a low stop bit
//   print_start/step/cpu_rst  one-cycle command pulses ('p', 's', 'r')
//   bp_addr/bp_valid          breakpoint address and armed flag
//   cmd_err                   one-cycle pulse on a malformed command
//
// state | meaning
// CMD   | expecting a single-character command
// HEX   | collecting up to 8 hex digits of a breakpoint address
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int baud_rate    = 9600,
    parameter int sys_clk_freq = 100_000_000,
    parameter int oversample   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        print_start,
    output logic        step,
    output logic        cpu_rst,
    output logic [31:0] bp_addr,
    output logic        bp_valid,
    output logic        cmd_err
);

    uart_rx #(
        .baud_rate   (baud_rate),
        .sys_clk_freq(sys_clk_freq),
        .oversample  (oversample)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    parse_state_t pstate, pstate_nx;
    logic [31:0]  acc, acc_nx, bp_addr_nx;
    logic [3:0]   ndig, ndig_nx;
    logic         bp_valid_nx, print_nx, step_nx, cpu_rst_nx, cmd_err_nx;
    logic [4:0]   nib;

    assign nib = hex_nibble(rx_byte);

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate      <= CMD;
            acc         <= '0;
            ndig        <= '0;
            bp_addr     <= '0;
            bp_valid    <= 1'b0;
            print_start <= 1'b0;
            step        <= 1'b0;
            cpu_rst     <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            pstate      <= pstate_nx;
            acc         <= acc_nx;
            ndig        <= ndig_nx;
            bp_addr     <= bp_addr_nx;
            bp_valid    <= bp_valid_nx;
            print_start <= print_nx;
            step        <= step_nx;
            cpu_rst     <= cpu_rst_nx;
            cmd_err     <= cmd_err_nx;
        end
    end

    always_comb begin
        pstate_nx   = pstate;
        acc_nx      = acc;
        ndig_nx     = ndig;
        bp_addr_nx  = bp_addr;
        bp_valid_nx = bp_valid;
        print_nx    = 1'b0;
        step_nx     = 1'b0;
        cpu_rst_nx  = 1'b0;
        cmd_err_nx  = 1'b0;
        if (rx_valid) begin
            case (pstate)
                CMD: begin
                    case (rx_byte)
                        CMD_PRINT: print_nx    = 1'b1;
                        CMD_STEP:  step_nx     = 1'b1;
                        CMD_RST:   cpu_rst_nx  = 1'b1;
                        CMD_CLR:   bp_valid_nx = 1'b0;
                        CMD_BP: begin
                            pstate_nx = HEX;
                            acc_nx    = '0;
                            ndig_nx   = '0;
                        end
                        CR, LF, SP: begin
                        end
                        default:   cmd_err_nx  = 1'b1;
                    endcase
                end
                HEX: begin
                    if (nib[4]) begin
                        if (ndig == 4'd8) begin
                            cmd_err_nx = 1'b1;
                            pstate_nx  = CMD;
                        end else begin
                            acc_nx  = {acc[27:0], nib[3:0]};
                            ndig_nx = ndig + 1'b1;
                        end
                    end else if (rx_byte == CR || rx_byte == LF) begin
                        // acc starts at zero, so short addresses are zero-extended
                        if (ndig != 4'd0) begin
                            bp_addr_nx  = acc;
                            bp_valid_nx = 1'b1;
                        end else begin
                            cmd_err_nx = 1'b1;
                        end
                        pstate_nx = CMD;
                    end else begin
                        cmd_err_nx = 1'b1;
                        pstate_nx  = CMD;
                    end
                end
                default: pstate_nx = CMD;
            endcase
        end
    end

endmodule
